// File: rtl/aximm_window_ctrl.sv
// AXI4-Lite register block owning the aximm_window base address; commits apply only with no bursts in flight.
// Optional feature macro WINCTRL_ALIGN_EN: pending[WIN_ALIGN-1:0] is forced to 0 and misaligned PEND_LO writes return SLVERR.
module aximm_window_ctrl #(
  parameter logic [63:0] RESET_WINDOW = 64'h0,
  parameter int unsigned CW           = 8,
  parameter int unsigned WIN_ALIGN    = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic        mon_aw_hs,
  input  logic        mon_b_hs,
  input  logic        mon_ar_hs,
  input  logic        mon_rlast_hs,
  output logic [63:0] window_addr,
  output logic        window_hold
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_APPLY = 2'd2} state_t;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
`ifdef WINCTRL_ALIGN_EN
  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << WIN_ALIGN) - 64'd1);
`else
  localparam logic [63:0] ALIGN_MASK = {64{1'b1}};
`endif

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [7:0] ext8(input logic [CW-1:0] v);
    logic [CW+7:0] wide;
    wide = {8'h00, v};
    return wide[7:0];
  endfunction

  // Simultaneous increment and decrement cancel; the count never wraps.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt, input logic inc, input logic dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != CNT_MAX) res = cnt + CNT_ONE;
    if (dec && !inc && cnt != CNT_ZERO) res = cnt - CNT_ONE;
    return res;
  endfunction

  logic          awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
  logic [1:0]    bresp_r, rresp_r;
  logic [31:0]   rdata_r, wdata_r;
  logic          aw_held_r, w_held_r;
  logic [1:0]    aw_idx_r;
  logic [3:0]    wstrb_r;
  logic [63:0]   pending_r, window_r;
  logic [CW-1:0] wr_out_r, rd_out_r;
  logic          hold_r;
  state_t        state_r, state_n;

  logic          aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s;
  logic          aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [31:0]   lo_new_s, hi_new_s, status_s, rd_mux_s;
  logic          misaligned_s, commit_s;
  logic          unused_s;

  assign unused_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Channel handshakes, next-state of the AXI4-Lite flags, write merge and read mux.
  always_comb begin
    aw_hs_s      = S_AXI_AWVALID & awready_r;
    w_hs_s       = S_AXI_WVALID & wready_r;
    ar_hs_s      = S_AXI_ARVALID & arready_r;
    wr_fire_s    = aw_held_r & w_held_r;
    aw_held_n    = (aw_held_r | aw_hs_s) & ~wr_fire_s;
    w_held_n     = (w_held_r | w_hs_s) & ~wr_fire_s;
    bvalid_n     = wr_fire_s | (bvalid_r & ~S_AXI_BREADY);
    rvalid_n     = ar_hs_s | (rvalid_r & ~S_AXI_RREADY);
    lo_new_s     = merge_strb(pending_r[31:0], wdata_r, wstrb_r);
    hi_new_s     = merge_strb(pending_r[63:32], wdata_r, wstrb_r);
    misaligned_s = (aw_idx_r == 2'd0) & (|(lo_new_s & ~ALIGN_MASK[31:0]));
    commit_s     = wr_fire_s & (aw_idx_r == 2'd2) & wstrb_r[0] & wdata_r[0];
    status_s     = {8'h00, ext8(rd_out_r), ext8(wr_out_r), 6'b000000,
                    (wr_out_r == CNT_ZERO) & (rd_out_r == CNT_ZERO), state_r != ST_IDLE};
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux_s = pending_r[31:0];
      2'd1:    rd_mux_s = pending_r[63:32];
      2'd3:    rd_mux_s = status_s;
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // AXI4-Lite handshake flags, latched AW/W beats and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      arready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_idx_r  <= 2'd0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= RESP_OKAY;
    end else begin
      aw_held_r <= aw_held_n;
      w_held_r  <= w_held_n;
      bvalid_r  <= bvalid_n;
      rvalid_r  <= rvalid_n;
      awready_r <= ~bvalid_n & ~aw_held_n;
      wready_r  <= ~bvalid_n & ~w_held_n;
      arready_r <= ~rvalid_n;
      if (aw_hs_s) aw_idx_r <= S_AXI_AWADDR[3:2];
      if (w_hs_s) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
      end
      if (ar_hs_s) begin
        rdata_r <= rd_mux_s;
        rresp_r <= RESP_OKAY;
      end
    end
  end

  // Pending window register and the write response code.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r <= RESET_WINDOW;
      bresp_r   <= RESP_OKAY;
    end else if (wr_fire_s) begin
      case (aw_idx_r)
        2'd0:    pending_r[31:0]  <= lo_new_s & ALIGN_MASK[31:0];
        2'd1:    pending_r[63:32] <= hi_new_s & ALIGN_MASK[63:32];
        default: pending_r        <= pending_r;
      endcase
      bresp_r <= misaligned_s ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Outstanding-burst counters for the monitored AXI4 path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_out_r <= CNT_ZERO;
      rd_out_r <= CNT_ZERO;
    end else begin
      wr_out_r <= next_count(wr_out_r, mon_aw_hs, mon_b_hs);
      rd_out_r <= next_count(rd_out_r, mon_ar_hs, mon_rlast_hs);
    end
  end

  // Commit FSM next state; a new burst starting this cycle blocks the apply.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) state_n = ST_PEND;
        else          state_n = ST_IDLE;
      end
      ST_PEND: begin
        if (wr_out_r == CNT_ZERO && rd_out_r == CNT_ZERO && !mon_aw_hs && !mon_ar_hs) state_n = ST_APPLY;
        else                                                                      state_n = ST_PEND;
      end
      ST_APPLY: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Commit FSM state, live window and hold output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      window_r <= RESET_WINDOW;
      hold_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      hold_r  <= (state_n != ST_IDLE);
      if (state_r == ST_APPLY) window_r <= pending_r;
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign window_addr   = window_r;
  assign window_hold   = hold_r;
endmodule
